id_ex_operand_stage: RTL and testbench

//   ID->EX pipeline register feeding the ALU. Resolves opr1/opr2 (reg, shamt, PC, imm, const 8) with
//   EX/MEM/WB forwarding, detects load-use hazards (inserts bubble), and registers operands, alu_op and

---
 rtl/id_ex_operand_stage_pkg.sv | 49 ++++
 rtl/id_ex_operand_stage_operand_fwd_mux.sv | 42 ++++
 rtl/id_ex_operand_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants, source-select layout and operand-use helpers for the ID->EX operand stage.
package id_ex_operand_stage_pkg;

  localparam int unsigned AOP_W     = 12;
  localparam int unsigned SRC_SEL_W = 5;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned ZERO_REG  = 0;

  // Bit positions inside id_src_sel
  localparam int unsigned ID_SRC_IS_8   = 0;
  localparam int unsigned ID_SRC_ZEXT   = 1;
  localparam int unsigned ID_SRC_IMM    = 2;
  localparam int unsigned ID_SRC_IS_PC  = 3;
  localparam int unsigned ID_SRC_IS_SA  = 4;

  // One-hot ALU op bit positions
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  typedef struct packed {
    logic src1_is_sa;
    logic src1_is_pc;
    logic src2_is_imm;
    logic imm_zext;
    logic src2_is_8;
  } src_sel_t;

  // rs is consumed unless operand 1 comes from shamt or PC
  function automatic logic reads_rs(input src_sel_t sel);
    return ~(sel.src1_is_sa | sel.src1_is_pc);
  endfunction

  // rt feeds operand 2 when no imm/const is selected; a non-writing imm instr is a store and needs rt as data
  function automatic logic reads_rt(input src_sel_t sel, input logic wen);
    return (~sel.src2_is_imm & ~sel.src2_is_8) | (~wen & sel.src2_is_imm);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_fwd_mux.sv
// Per-source bypass mux: picks EX > MEM > WB > regfile, $zero always reads 0; flags a not-yet-ready EX hit.
module id_ex_operand_stage_operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ex_data_ok,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data_c,
  output logic              ex_pending_c
);

  logic nonzero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  always_comb begin
    nonzero      = (addr != REG_AW'(ZERO_REG));
    ex_hit       = nonzero & ex_wen  & (ex_dest  == addr);
    mem_hit      = nonzero & mem_wen & (mem_dest == addr);
    wb_hit       = nonzero & wb_wen  & (wb_dest  == addr);
    ex_pending_c = ex_hit & ~ex_data_ok;
    data_c       = rf_data;
    if (!nonzero)     data_c = '0;
    else if (ex_hit)  data_c = ex_data;
    else if (mem_hit) data_c = mem_data;
    else if (wb_hit)  data_c = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: operand selection with forwarding, load-use bubble, valid/allowin handshake.
// Optional ID_EX_PERF_EN adds perf_bubble_cnt counting inserted hazard bubbles.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [DATA_W-1:0]    id_pc,
  input  logic [REG_AW-1:0]    id_rs_addr,
  input  logic [REG_AW-1:0]    id_rt_addr,
  input  logic [DATA_W-1:0]    id_rs_data,
  input  logic [DATA_W-1:0]    id_rt_data,
  input  logic [IMM_W-1:0]     id_imm,
  input  logic [SHAMT_W-1:0]   id_shamt,
  input  logic [SRC_SEL_W-1:0] id_src_sel,
  input  logic [AOP_W-1:0]     id_alu_op,
  input  logic [REG_AW-1:0]    id_dest,
  input  logic                 id_wen,
  input  logic                 id_is_load,
  input  logic                 ex_fwd_wen,
  input  logic [REG_AW-1:0]    ex_fwd_dest,
  input  logic [DATA_W-1:0]    ex_fwd_data,
  input  logic                 ex_fwd_data_ok,
  input  logic                 mem_fwd_wen,
  input  logic [REG_AW-1:0]    mem_fwd_dest,
  input  logic [DATA_W-1:0]    mem_fwd_data,
  input  logic                 wb_fwd_wen,
  input  logic [REG_AW-1:0]    wb_fwd_dest,
  input  logic [DATA_W-1:0]    wb_fwd_data,
  input  logic                 ex_allowin,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [DATA_W-1:0]    ex_opr1,
  output logic [DATA_W-1:0]    ex_opr2,
  output logic [DATA_W-1:0]    ex_store_data,
  output logic [AOP_W-1:0]     ex_alu_op,
  output logic [REG_AW-1:0]    ex_dest,
  output logic                 ex_wen,
`ifdef ID_EX_PERF_EN
  output logic [31:0]          perf_bubble_cnt,
`endif
  output logic                 ex_is_load
);

  localparam int unsigned IMM_PAD = DATA_W - IMM_W;
  localparam int unsigned SA_PAD  = DATA_W - SHAMT_W;

  src_sel_t          sel;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] opr1;
  logic [DATA_W-1:0] opr2;
  logic              rs_pending;
  logic              rt_pending;
  logic              rs_read;
  logic              rt_read;
  logic              hazard;
  logic              load_en;
  logic              enter;

  id_ex_operand_stage_operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_mux (
    .addr         (id_rs_addr),
    .rf_data      (id_rs_data),
    .ex_wen       (ex_fwd_wen),
    .ex_dest      (ex_fwd_dest),
    .ex_data      (ex_fwd_data),
    .ex_data_ok   (ex_fwd_data_ok),
    .mem_wen      (mem_fwd_wen),
    .mem_dest     (mem_fwd_dest),
    .mem_data     (mem_fwd_data),
    .wb_wen       (wb_fwd_wen),
    .wb_dest      (wb_fwd_dest),
    .wb_data      (wb_fwd_data),
    .data_c       (rs_fwd),
    .ex_pending_c (rs_pending)
  );

  id_ex_operand_stage_operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_mux (
    .addr         (id_rt_addr),
    .rf_data      (id_rt_data),
    .ex_wen       (ex_fwd_wen),
    .ex_dest      (ex_fwd_dest),
    .ex_data      (ex_fwd_data),
    .ex_data_ok   (ex_fwd_data_ok),
    .mem_wen      (mem_fwd_wen),
    .mem_dest     (mem_fwd_dest),
    .mem_data     (mem_fwd_data),
    .wb_wen       (wb_fwd_wen),
    .wb_dest      (wb_fwd_dest),
    .wb_data      (wb_fwd_data),
    .data_c       (rt_fwd),
    .ex_pending_c (rt_pending)
  );

  // Hazard detection, handshake and operand selection
  always_comb begin
    sel      = src_sel_t'(id_src_sel);
    rs_read  = reads_rs(sel);
    rt_read  = reads_rt(sel, id_wen);
    hazard   = id_valid & ((rs_read & rs_pending) | (rt_read & rt_pending));
    load_en  = ~ex_valid | ex_allowin;
    id_ready = flush | (load_en & ~hazard);
    enter    = load_en & id_valid & ~hazard & ~flush;

    opr1 = rs_fwd;
    if (sel.src1_is_sa)      opr1 = {{SA_PAD{1'b0}}, id_shamt};
    else if (sel.src1_is_pc) opr1 = id_pc;

    opr2 = rt_fwd;
    if (sel.src2_is_imm) begin
      if (sel.imm_zext) opr2 = {{IMM_PAD{1'b0}}, id_imm};
      else              opr2 = {{IMM_PAD{id_imm[IMM_W-1]}}, id_imm};
    end else if (sel.src2_is_8) begin
      opr2 = DATA_W'(8);
    end
  end

  // Pipeline register; payload only changes when a new valid instruction enters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_opr1       <= '0;
      ex_opr2       <= '0;
      ex_store_data <= '0;
      ex_alu_op     <= '0;
      ex_dest       <= '0;
      ex_wen        <= 1'b0;
      ex_is_load    <= 1'b0;
    end else begin
      if (flush)        ex_valid <= 1'b0;
      else if (load_en) ex_valid <= id_valid & ~hazard;
      if (enter) begin
        ex_pc         <= id_pc;
        ex_opr1       <= opr1;
        ex_opr2       <= opr2;
        ex_store_data <= rt_fwd;
        ex_alu_op     <= id_alu_op;
        ex_dest       <= id_dest;
        ex_wen        <= id_wen;
        ex_is_load    <= id_is_load;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  // Counts cycles where a load-use bubble is inserted; wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          perf_bubble_cnt <= 32'd0;
    else if (hazard & load_en & ~flush)   perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed + random bench for id_ex_operand_stage against a behavioural pipeline-register model.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic        clk, resetn, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_src_sel, id_dest;
  logic [15:0] id_imm;
  logic [11:0] id_alu_op;
  logic        id_wen, id_is_load;
  logic        ex_fwd_wen, ex_fwd_data_ok, mem_fwd_wen, wb_fwd_wen, ex_allowin;
  logic [4:0]  ex_fwd_dest, mem_fwd_dest, wb_fwd_dest;
  logic [31:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_wen, ex_is_load;
  logic [31:0] ex_pc, ex_opr1, ex_opr2, ex_store_data;
  logic [11:0] ex_alu_op;
  logic [4:0]  ex_dest;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference state: what the EX-side register should hold
  logic        m_valid, m_wen, m_load;
  logic [31:0] m_pc, m_opr1, m_opr2, m_sd;
  logic [11:0] m_aop;
  logic [4:0]  m_dest;
  logic [31:0] m_bub;

  id_ex_operand_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_src_sel(id_src_sel), .id_alu_op(id_alu_op), .id_dest(id_dest), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_fwd_wen(ex_fwd_wen), .ex_fwd_dest(ex_fwd_dest),
    .ex_fwd_data(ex_fwd_data), .ex_fwd_data_ok(ex_fwd_data_ok), .mem_fwd_wen(mem_fwd_wen),
    .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data), .wb_fwd_wen(wb_fwd_wen),
    .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data), .ex_allowin(ex_allowin),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opr1(ex_opr1), .ex_opr2(ex_opr2),
    .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op), .ex_dest(ex_dest), .ex_wen(ex_wen),
`ifdef ID_EX_PERF_EN
    .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .ex_is_load(ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a source would read in ID given the current bypass network
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (ex_fwd_wen && ex_fwd_dest == a) return ex_fwd_data;
    if (mem_fwd_wen && mem_fwd_dest == a) return mem_fwd_data;
    if (wb_fwd_wen && wb_fwd_dest == a) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic ref_not_ready(input logic [4:0] a);
    return a != 5'd0 && ex_fwd_wen && ex_fwd_dest == a && !ex_fwd_data_ok;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wen = 0; m_load = 0; m_pc = 0; m_opr1 = 0; m_opr2 = 0; m_sd = 0;
    m_aop = 0; m_dest = 0; m_bub = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ":pc"}, ex_pc, m_pc);
    chk({tag, ":opr1"}, ex_opr1, m_opr1);
    chk({tag, ":opr2"}, ex_opr2, m_opr2);
    chk({tag, ":sdata"}, ex_store_data, m_sd);
    chk({tag, ":aop"}, 32'(ex_alu_op), 32'(m_aop));
    chk({tag, ":dest"}, 32'(ex_dest), 32'(m_dest));
    chk({tag, ":wen"}, 32'(ex_wen), 32'(m_wen));
    chk({tag, ":load"}, 32'(ex_is_load), 32'(m_load));
`ifdef ID_EX_PERF_EN
    chk({tag, ":perf"}, perf_bubble_cnt, m_bub);
`endif
  endtask

  // One clock: check id_ready before the edge, predict the register, check it after the edge
  task automatic step(input string tag);
    logic sa, pc, imm, zx, e8, rs_used, rt_used, hz, le, take;
    logic [31:0] o1, o2, sd;
    #1;
    {sa, pc, imm, zx, e8} = id_src_sel;
    rs_used = !(sa || pc);
    rt_used = (!imm && !e8) || (!id_wen && imm);
    hz = id_valid && ((rs_used && ref_not_ready(id_rs_addr)) || (rt_used && ref_not_ready(id_rt_addr)));
    le = !m_valid || ex_allowin;
    o1 = sa ? 32'(id_shamt) : pc ? id_pc : ref_read(id_rs_addr, id_rs_data);
    o2 = imm ? (zx ? 32'(id_imm) : 32'($signed(id_imm))) : e8 ? 32'd8 : ref_read(id_rt_addr, id_rt_data);
    sd = ref_read(id_rt_addr, id_rt_data);
    chk({tag, ":ready"}, 32'(id_ready), 32'(flush || (le && !hz)));
    take = !flush && le && id_valid && !hz;
    if (hz && le && !flush) m_bub = m_bub + 1;
    @(posedge clk);
    #1;
    if (flush) m_valid = 0;
    else if (le) m_valid = id_valid && !hz;
    if (take) begin
      m_pc = id_pc; m_opr1 = o1; m_opr2 = o2; m_sd = sd; m_aop = id_alu_op;
      m_dest = id_dest; m_wen = id_wen; m_load = id_is_load;
    end
    check_outputs(tag);
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; id_pc = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0;
    id_rt_data = 0; id_imm = 0; id_shamt = 0; id_src_sel = 0; id_alu_op = 0; id_dest = 0;
    id_wen = 0; id_is_load = 0; ex_fwd_wen = 0; ex_fwd_dest = 0; ex_fwd_data = 0;
    ex_fwd_data_ok = 1; mem_fwd_wen = 0; mem_fwd_dest = 0; mem_fwd_data = 0; wb_fwd_wen = 0;
    wb_fwd_dest = 0; wb_fwd_data = 0; ex_allowin = 1;
  endtask

  task automatic randomize_inputs();
    flush = ($urandom_range(0, 9) == 0);
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom); id_shamt = 5'($urandom);
    id_src_sel = 5'($urandom); id_alu_op = 12'(1) << $urandom_range(0, 11);
    id_dest = 5'($urandom); id_wen = 1'($urandom); id_is_load = 1'($urandom);
    ex_fwd_wen = 1'($urandom); ex_fwd_dest = 5'($urandom_range(0, 3)); ex_fwd_data = $urandom;
    ex_fwd_data_ok = ($urandom_range(0, 2) != 0);
    mem_fwd_wen = 1'($urandom); mem_fwd_dest = 5'($urandom_range(0, 3)); mem_fwd_data = $urandom;
    wb_fwd_wen = 1'($urandom); wb_fwd_dest = 5'($urandom_range(0, 3)); wb_fwd_data = $urandom;
    ex_allowin = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    idle();
    model_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    resetn = 1;

    // addiu $2,$1,-1 with $1=5
    id_valid = 1; id_pc = 32'h0000_1000; id_rs_addr = 1; id_rs_data = 5; id_rt_addr = 2;
    id_src_sel = 5'b00100; id_imm = 16'hFFFF; id_alu_op = 12'(1) << ALU_ADD; id_dest = 2; id_wen = 1;
    step("t1");
    chk("t1_opr1", ex_opr1, 32'd5);
    chk("t1_opr2", ex_opr2, 32'hFFFF_FFFF);
    chk("t1_aop", 32'(ex_alu_op), 32'h1);

    // forwarding priority
    id_rs_addr = 3; id_rs_data = 32'h99;
    mem_fwd_wen = 1; mem_fwd_dest = 3; mem_fwd_data = 32'h10;
    wb_fwd_wen = 1; wb_fwd_dest = 3; wb_fwd_data = 32'h20;
    step("t2a");
    chk("t2_mem", ex_opr1, 32'h10);
    ex_fwd_wen = 1; ex_fwd_dest = 3; ex_fwd_data = 32'h30; ex_fwd_data_ok = 1;
    step("t2b");
    chk("t2_ex", ex_opr1, 32'h30);

    // load-use: lw $4 in EX, consumer reads $4
    idle(); id_valid = 1; id_rs_addr = 4; id_src_sel = 5'b00100; id_imm = 16'h4; id_dest = 7; id_wen = 1;
    ex_fwd_wen = 1; ex_fwd_dest = 4; ex_fwd_data = 32'hBAD; ex_fwd_data_ok = 0;
    step("t3a");
    chk("t3_bubble", 32'(ex_valid), 32'd0);
    ex_fwd_wen = 0; mem_fwd_wen = 1; mem_fwd_dest = 4; mem_fwd_data = 32'h44;
    step("t3b");
    chk("t3_memfwd", ex_opr1, 32'h44);

    // $zero never forwarded; sll uses shamt
    idle(); id_valid = 1; id_rs_addr = 0; id_rs_data = 32'h55; id_src_sel = 5'b00100; id_wen = 1;
    ex_fwd_wen = 1; ex_fwd_dest = 0; ex_fwd_data = 32'hDEAD;
    step("t4a");
    chk("t4_zero", ex_opr1, 32'd0);
    idle(); id_valid = 1; id_src_sel = 5'b10000; id_shamt = 7; id_rt_addr = 5; id_rt_data = 32'h1234;
    id_alu_op = 12'(1) << ALU_SLL; id_dest = 6; id_wen = 1;
    step("t4b");
    chk("t4_sa", ex_opr1, 32'd7);
    chk("t4_rt", ex_opr2, 32'h1234);

    // stall then flush
    id_pc = 32'h2000; id_shamt = 9; ex_allowin = 0;
    step("t5a");
    step("t5b");
    chk("t5_held", ex_opr1, 32'd7);
    flush = 1;
    step("t5c");
    chk("t5_flush", 32'(ex_valid), 32'd0);

    // async reset while a hazard is stalling
    idle(); id_valid = 1; id_pc = 32'h3000; id_src_sel = 5'b00001; id_wen = 1; id_dest = 3;
    step("t6load");
    id_rs_addr = 6; ex_fwd_wen = 1; ex_fwd_dest = 6; ex_fwd_data_ok = 0; ex_allowin = 0;
    step("t6stall");
    resetn = 0;
    #2;
    model_reset();
    check_outputs("t6_async");
    @(posedge clk);
    #1;
    resetn = 1;
    ex_allowin = 1;
    step("t6b1");
    step("t6b2");
    step("t6b3");
`ifdef ID_EX_PERF_EN
    chk("t6_perf3", perf_bubble_cnt, 32'd3);
`endif

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
